// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: reset sequencer and cycle-budget run controller for the CPU.
// Holds the CPU in reset for RST_CYCLES enabled cycles, then lets it run for
// at most MAX_CYCLES cycles, then freezes it (clock disabled, reset low).
// Optional feature macro: CPU_RUN_HALT_EN (halt_in ends RUN early).
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 6,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_in,
    output logic             cpu_reset,
    output logic             cpu_clk_en,
    output logic             run,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             halted_nxt, timeout_nxt;
    logic             cpu_reset_nxt, cpu_clk_en_nxt, run_nxt, done_nxt;
    logic             halt_eff;

`ifdef CPU_RUN_HALT_EN
    assign halt_eff = halt_in;
`else
    // halt_in is kept on the port list but has no effect in this build.
    logic unused_halt;
    assign unused_halt = halt_in;
    assign halt_eff    = 1'b0;
`endif

    // Next-state, counters and status; outputs are decoded from the next
    // state so that they can be registered alongside it.
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        cnt_nxt     = cycle_count;
        halted_nxt  = halted;
        timeout_nxt = timeout;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_RESET;
                    rst_cnt_nxt = '0;
                    cnt_nxt     = '0;
                    halted_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt == RST_LAST) state_nxt = ST_RUN;
                else rst_cnt_nxt = rst_cnt + ONE;
            end
            ST_RUN: begin
                // The terminating edge still counts as an executed cycle.
                cnt_nxt = cycle_count + ONE;
                if (halt_eff) begin
                    state_nxt  = ST_DONE;
                    halted_nxt = 1'b1;
                end else if (cycle_count == RUN_LAST) begin
                    state_nxt   = ST_DONE;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        cpu_reset_nxt  = (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
        cpu_clk_en_nxt = (state_nxt == ST_RESET) || (state_nxt == ST_RUN);
        run_nxt        = (state_nxt == ST_RUN);
        done_nxt       = (state_nxt == ST_DONE);
    end

    // State, counters and registered outputs; async reset parks in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cpu_reset   <= 1'b1;
            cpu_clk_en  <= 1'b0;
            run         <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            cycle_count <= cnt_nxt;
            halted      <= halted_nxt;
            timeout     <= timeout_nxt;
            cpu_reset   <= cpu_reset_nxt;
            cpu_clk_en  <= cpu_clk_en_nxt;
            run         <= run_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl with default parameters.
module tb_cpu_run_ctrl;

    localparam int RST_CYCLES = 2;
    localparam int MAX_CYCLES = 6;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             reset, start, halt_in;
    logic             cpu_reset, cpu_clk_en, run, done, halted, timeout;
    logic [CNT_W-1:0] cycle_count;

    typedef struct {
        int cnt;
        int hlt;
        int tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    cpu_run_ctrl #(.RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_in(halt_in),
        .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en), .run(run), .done(done),
        .halted(halted), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cpu_reset"}, int'(cpu_reset), 1);
        chk({tag, " cpu_clk_en"}, int'(cpu_clk_en), 0);
        chk({tag, " run"}, int'(run), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " halted"}, int'(halted), 0);
        chk({tag, " timeout"}, int'(timeout), 0);
        chk({tag, " cycle_count"}, int'(cycle_count), 0);
    endtask

    // One full sequence. halt_at: RUN edge (1-based) carrying halt_in, 0 = none.
    // hold_start keeps start high through RESET/RUN; halt_rst pulses halt_in in RESET.
    task automatic do_seq(input string tag, input int halt_at, input bit hold_start,
                          input bit halt_rst);
        exp_t e;
        int   n;
        int   k;
        bit   got_done;
`ifdef CPU_RUN_HALT_EN
        if (halt_at >= 1 && halt_at <= MAX_CYCLES) begin
            e.cnt = halt_at; e.hlt = 1; e.tmo = 0;
        end else begin
            e.cnt = MAX_CYCLES; e.hlt = 0; e.tmo = 1;
        end
`else
        e.cnt = MAX_CYCLES; e.hlt = 0; e.tmo = 1;
`endif
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);                       // after E0: RESET entered
        if (!hold_start) start = 1'b0;
        halt_in = halt_rst;
        chk({tag, " E0 cpu_reset"}, int'(cpu_reset), 1);
        chk({tag, " E0 cpu_clk_en"}, int'(cpu_clk_en), 1);
        chk({tag, " E0 cleared"}, int'(cycle_count) + int'(halted) + int'(timeout) + int'(done), 0);

        n = 0;
        while (!run && n < RST_CYCLES + 4) begin
            @(negedge clk);
            n++;
            if (!run) chk({tag, " reset held"}, int'(cpu_reset), 1);
        end
        halt_in = 1'b0;
        chk({tag, " edges to RUN"}, n, RST_CYCLES);
        chk({tag, " RUN cpu_reset"}, int'(cpu_reset), 0);

        k = 0;
        got_done = 1'b0;
        while (!got_done && k < MAX_CYCLES + 4) begin
            k++;
            halt_in = (k == halt_at);
            @(negedge clk);
            if (done) got_done = 1'b1;
            else chk({tag, " run high"}, int'(run), 1);
        end
        halt_in = 1'b0;
        start   = 1'b0;
        chk({tag, " done reached"}, int'(got_done), 1);

        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " run edges"}, k, e.cnt);
            chk({tag, " cycle_count"}, int'(cycle_count), e.cnt);
            chk({tag, " halted"}, int'(halted), e.hlt);
            chk({tag, " timeout"}, int'(timeout), e.tmo);
            chk({tag, " frozen"}, {int'(cpu_reset), int'(cpu_clk_en), int'(run)}, 0);
        end
        @(negedge clk);
        chk({tag, " stays done"}, int'(done), 1);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; halt_in = 1'b0;
        #1;
        chk_idle("por");
        #20;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle("idle hold");

        do_seq("budget", 0, 1'b0, 1'b0);
        do_seq("halt3", 3, 1'b0, 1'b1);      // also restart from DONE
        do_seq("halt6", MAX_CYCLES, 1'b0, 1'b0);
        do_seq("holdstart", 0, 1'b1, 1'b0);
        do_seq("halt1", 1, 1'b0, 1'b0);

        // Async reset in the middle of RUN, after the 4th RUN edge.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!run && k < RST_CYCLES + 4) begin
            @(negedge clk);
            k++;
        end
        chk("mid run reached", int'(run), 1);
        repeat (4) @(posedge clk);
        #2;
        chk("mid run count", int'(cycle_count), 4);
        reset = 1'b1;
        #1;
        chk_idle("async reset");
        @(negedge clk);
        chk_idle("reset held");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("after reset");
        do_seq("post reset", 0, 1'b0, 1'b0);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
